music_playlist_ctrl: RTL

Next-generation player control FSM that sequences a playlist of NUM_SONGS tracks instead of a single song. Takes single-cycle button pulses (play_pause, next, prev) and the song_done flag from the note sequencer. Drives play/reset_play to the sequencer and song_sel to the song ROM mux. Adds previous-track, index wrap, repeat modes, and a playlist-end indication.

---
 rtl/music_playlist_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/music_playlist_ctrl.sv
// Playlist player controller: sequences NUM_SONGS tracks with next/prev, wrap and repeat modes.
// Optional shuffle support is compiled in with `define MUSIC_PLAYLIST_SHUFFLE_EN.
module music_playlist_ctrl #(
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_pause,
    input  logic              next,
    input  logic              prev,
    input  logic              song_done,
    input  logic [1:0]        repeat_mode,
`ifdef MUSIC_PLAYLIST_SHUFFLE_EN
    input  logic              shuffle,
`endif
    output logic              play,
    output logic              reset_play,
    output logic [SONG_W-1:0] song_sel,
    output logic              new_song,
    output logic              playlist_done
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        PAUSE = 2'd1,
        LOAD  = 2'd2,
        PLAY  = 2'd3
    } state_t;

    localparam logic [SONG_W:0] N_EXT = (SONG_W+1)'(NUM_SONGS);
    localparam logic [SONG_W:0] LAST  = (SONG_W+1)'(NUM_SONGS - 1);
    localparam logic [SONG_W:0] ONE   = (SONG_W+1)'(1);

    state_t            state, state_n;
    logic              play_n, reset_play_n, new_song_n, playlist_done_n;
    logic              go_play, go_play_n;
    logic [SONG_W-1:0] song_sel_n;
    logic [SONG_W-1:0] adv_idx;
    logic              list_end;
    logic              load_en, load_go;
    logic [SONG_W-1:0] load_idx;

    // Index arithmetic carries one extra bit so the wrap compare cannot overflow.
    function automatic logic [SONG_W-1:0] inc_idx(input logic [SONG_W-1:0] i);
        logic [SONG_W:0] s;
        s = {1'b0, i} + ONE;
        if (s >= N_EXT) s = '0;
        return s[SONG_W-1:0];
    endfunction

    function automatic logic [SONG_W-1:0] dec_idx(input logic [SONG_W-1:0] i);
        logic [SONG_W:0] s;
        s = {1'b0, i};
        if (s == '0) s = LAST;
        else         s = s - ONE;
        return s[SONG_W-1:0];
    endfunction

`ifdef MUSIC_PLAYLIST_SHUFFLE_EN
    logic [7:0]      lfsr;
    logic [SONG_W:0] adv_cnt;
    logic            user_skip, rep00_adv;

    // Candidate folded into range with one subtraction; never repeats the current track.
    function automatic logic [SONG_W-1:0] shuf_pick(input logic [SONG_W-1:0] i,
                                                    input logic [7:0]        l);
        logic [SONG_W:0] c;
        c = {1'b0, l[SONG_W-1:0]};
        if (c >= N_EXT) c = c - N_EXT;
        if (c[SONG_W-1:0] == i) return inc_idx(i);
        return c[SONG_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) lfsr <= 8'hA5;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign user_skip = ((state == PAUSE) || (state == PLAY)) && !play_pause && (next || prev);
    assign rep00_adv = (state == PLAY) && !play_pause && !next && !prev && song_done &&
                       ((repeat_mode == 2'b00) || (repeat_mode == 2'b11));

    // Counts automatic advances so a shuffled stop-at-end playlist still terminates.
    always_ff @(posedge clk) begin
        if (reset || user_skip)  adv_cnt <= '0;
        else if (rep00_adv)      adv_cnt <= list_end ? '0 : adv_cnt + ONE;
    end

    assign adv_idx  = shuffle ? shuf_pick(song_sel, lfsr) : inc_idx(song_sel);
    assign list_end = shuffle ? (adv_cnt == LAST) : ({1'b0, song_sel} == LAST);
`else
    assign adv_idx  = inc_idx(song_sel);
    assign list_end = ({1'b0, song_sel} == LAST);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= INIT;
            play          <= 1'b0;
            reset_play    <= 1'b1;
            song_sel      <= '0;
            new_song      <= 1'b0;
            playlist_done <= 1'b0;
            go_play       <= 1'b0;
        end else begin
            state         <= state_n;
            play          <= play_n;
            reset_play    <= reset_play_n;
            song_sel      <= song_sel_n;
            new_song      <= new_song_n;
            playlist_done <= playlist_done_n;
            go_play       <= go_play_n;
        end
    end

    always_comb begin
        state_n         = state;
        play_n          = play;
        reset_play_n    = reset_play;
        song_sel_n      = song_sel;
        new_song_n      = 1'b0;
        playlist_done_n = 1'b0;
        go_play_n       = go_play;
        load_en         = 1'b0;
        load_go         = 1'b0;
        load_idx        = song_sel;

        case (state)
            INIT: begin
                state_n      = PAUSE;
                reset_play_n = 1'b0;
                play_n       = 1'b0;
            end
            PAUSE: begin
                if (play_pause) begin
                    state_n = PLAY;
                    play_n  = 1'b1;
                end else if (next) begin
                    load_en  = 1'b1;
                    load_idx = adv_idx;
                    load_go  = 1'b1;
                end else if (prev) begin
                    load_en  = 1'b1;
                    load_idx = dec_idx(song_sel);
                    load_go  = 1'b1;
                end
            end
            PLAY: begin
                if (play_pause) begin
                    state_n = PAUSE;
                    play_n  = 1'b0;
                end else if (next) begin
                    load_en  = 1'b1;
                    load_idx = adv_idx;
                    load_go  = 1'b1;
                end else if (prev) begin
                    load_en  = 1'b1;
                    load_idx = dec_idx(song_sel);
                    load_go  = 1'b1;
                end else if (song_done) begin
                    load_en = 1'b1;
                    case (repeat_mode)
                        2'b10: begin
                            load_idx = song_sel;
                            load_go  = 1'b1;
                        end
                        2'b01: begin
                            load_idx = adv_idx;
                            load_go  = 1'b1;
                        end
                        default: begin
                            if (list_end) begin
                                load_idx        = '0;
                                load_go         = 1'b0;
                                playlist_done_n = 1'b1;
                            end else begin
                                load_idx = adv_idx;
                                load_go  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            LOAD: begin
                state_n      = go_play ? PLAY : PAUSE;
                play_n       = go_play;
                reset_play_n = 1'b0;
            end
            default: begin
                state_n      = PAUSE;
                play_n       = 1'b0;
                reset_play_n = 1'b0;
            end
        endcase

        // Any track change funnels through the single-cycle LOAD strobe.
        if (load_en) begin
            state_n      = LOAD;
            song_sel_n   = load_idx;
            go_play_n    = load_go;
            reset_play_n = 1'b1;
            new_song_n   = 1'b1;
            play_n       = 1'b0;
        end
    end

endmodule
